// File: rtl/control_unit.sv
// control_unit: one-hot T1-T6 ring with opcode decode into the datapath control word, run/step and halt.
module control_unit #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic       dummy_clk,
    input  logic       FPGA_inp_zero,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_out,
    output logic       acc_load,
    output logic       acc_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       sub,
    output logic       out_load,
    output logic       instr_done,
    output logic       halt
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } phase_e;

    phase_e     phase;
    logic       step_q;
    logic       adv;
    logic       lda, add, sub_op, sta, jmp, out_op, hlt, nop, mem;
    logic       last4, last5, wrap;
    logic [5:0] t;

    assign t_state = phase;

    assign lda    = opcode == 4'b0000;
    assign add    = opcode == 4'b0001;
    assign sub_op = opcode == 4'b0010;
    assign sta    = opcode == 4'b0011;
    assign jmp    = opcode == 4'b0100;
    assign out_op = opcode == 4'b1110;
    assign hlt    = opcode == 4'b1111;
    assign nop    = ~(lda | add | sub_op | sta | jmp | out_op | hlt);
    assign mem    = lda | add | sub_op | sta;

    // HLT always ends at T4; the short instructions end early only when EARLY_END is set
    assign last4 = hlt | (EARLY_END & (jmp | out_op | nop));
    assign last5 = EARLY_END & (lda | sta);

    assign adv  = ~halt & ~FPGA_inp_zero & (run | (step & ~step_q));
    assign t    = phase & {6{adv}};
    assign wrap = (t[3] & last4) | (t[4] & last5) | t[5];

    assign pc_out     = t[0];
    assign pc_inc     = t[1];
    assign pc_load    = t[3] & jmp;
    assign mar_load   = t[0] | (t[3] & mem);
    assign ram_out    = t[2] | (t[4] & (lda | add | sub_op));
    assign ram_we     = t[4] & sta;
    assign ir_load    = t[2];
    assign ir_out     = t[3] & (mem | jmp);
    assign acc_load   = (t[4] & lda) | (t[5] & (add | sub_op));
    assign acc_out    = (t[3] & out_op) | (t[4] & sta);
    assign b_load     = t[4] & (add | sub_op);
    assign alu_out    = t[5] & (add | sub_op);
    assign sub        = t[5] & sub_op;
    assign out_load   = t[3] & out_op;
    assign instr_done = wrap;

    // phase ring, sticky halt and step edge history
    always_ff @(posedge dummy_clk) begin
        if (FPGA_inp_zero) begin
            phase  <= T1;
            halt   <= 1'b0;
            step_q <= 1'b0;
        end else begin
            step_q <= step;
            if (adv) begin
                phase <= wrap ? T1 : phase_e'({phase[4:0], phase[5]});
                halt  <= t[3] & hlt;
            end
        end
    end
endmodule
